// File: rtl/coin_acceptor_pkg.sv
// rtl/coin_acceptor_pkg.sv - shared coin codes, coin value lookup and FSM states for coin_acceptor
package coin_pkg;

    localparam logic [1:0] COIN_10  = 2'd0;
    localparam logic [1:0] COIN_20  = 2'd1;
    localparam logic [1:0] COIN_100 = 2'd2;
    localparam logic [1:0] COIN_50  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        CLASSIFY,
        REPORT,
        JAM
    } state_t;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_10: return 7'd10;
            COIN_20: return 7'd20;
            COIN_50: return 7'd50;
            default: return 7'd100;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - coin interface between acceptor (master) and vending controller (slave); credit exists only with COIN_ACCEPTOR_TALLY_EN
interface coin_acceptor_if;

    logic       accept_en;
    logic [1:0] coin;
    logic       drop_coin;
    logic       finish_coin;
    logic       reject;
    logic       jam;
    logic       busy;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [10:0] credit;

    modport master (input accept_en,
                    output coin, drop_coin, finish_coin, reject, jam, busy, credit);
    modport slave  (output accept_en,
                    input coin, drop_coin, finish_coin, reject, jam, busy, credit);
`else
    modport master (input accept_en,
                    output coin, drop_coin, finish_coin, reject, jam, busy);
    modport slave  (output accept_en,
                    input coin, drop_coin, finish_coin, reject, jam, busy);
`endif

endinterface

// File: rtl/coin_acceptor_debouncer.sv
// rtl/coin_acceptor_debouncer.sv - 2-flop synchroniser plus DEB_CYCLES stability filter with rise pulse
module input_debouncer #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;

    // Both edges see the same delay, so a debounced pulse is as wide as the raw one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                level <= sync2;
                rise  <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin slot front-end: width measurement, classification, jam and session control
// Optional running credit output enabled by COIN_ACCEPTOR_TALLY_EN.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int MIN_WIDTH    = 8,
    parameter int T10_MAX      = 20,
    parameter int T20_MAX      = 40,
    parameter int T50_MAX      = 60,
    parameter int T100_MAX     = 80,
    parameter int CNT_W        = 8,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int TO_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sense,
    input  logic             done_btn,
    coin_acceptor_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic sense_lvl, sense_rise;
    logic done_lvl_unused, done_rise;

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_sense_deb (
        .clk(clk), .reset(reset), .raw(sense), .level(sense_lvl), .rise(sense_rise)
    );

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_done_deb (
        .clk(clk), .reset(reset), .raw(done_btn), .level(done_lvl_unused), .rise(done_rise)
    );

    state_t           state;
    logic [CNT_W-1:0] width;
    logic [TO_W-1:0]  to_cnt;
    logic             accept_q;
    logic             session_open;
    logic             coin_seen;
    logic             done_pend;

    logic accept_rise, to_hit, finish_req;
    assign accept_rise = bus.accept_en & ~accept_q;
    assign to_hit      = coin_seen && (to_cnt == TO_W'(IDLE_TIMEOUT - 1));
    assign finish_req  = session_open && bus.accept_en && (done_rise || done_pend || to_hit);

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [11:0] credit_sum;
    assign credit_sum = {1'b0, bus.credit} + 12'(coin_value(bus.coin));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            width           <= '0;
            to_cnt          <= '0;
            accept_q        <= 1'b0;
            session_open    <= 1'b0;
            coin_seen       <= 1'b0;
            done_pend       <= 1'b0;
            bus.coin        <= COIN_10;
            bus.drop_coin   <= 1'b0;
            bus.finish_coin <= 1'b0;
            bus.reject      <= 1'b0;
            bus.jam         <= 1'b0;
            bus.busy        <= 1'b0;
`ifdef COIN_ACCEPTOR_TALLY_EN
            bus.credit      <= '0;
`endif
        end else begin
            accept_q        <= bus.accept_en;
            bus.drop_coin   <= 1'b0;
            bus.finish_coin <= 1'b0;
            bus.reject      <= 1'b0;

            if (!bus.accept_en)
                done_pend <= 1'b0;
            else if (done_rise && state != IDLE && session_open)
                done_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (finish_req) begin
                        bus.finish_coin <= 1'b1;
                        session_open    <= 1'b0;
                        done_pend       <= 1'b0;
                    end else if (session_open && coin_seen && !to_hit) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    // The rise cycle itself is the first high cycle of the coin.
                    if (sense_rise) begin
                        width    <= CNT_W'(1);
                        state    <= MEASURE;
                        bus.busy <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!sense_lvl) begin
                        state <= CLASSIFY;
                    end else if (width == CNT_MAX) begin
                        state      <= JAM;
                        bus.jam    <= 1'b1;
                        bus.reject <= 1'b1;
                    end else begin
                        width <= width + 1'b1;
                    end
                end
                CLASSIFY: begin
                    if (width < CNT_W'(MIN_WIDTH) || width > CNT_W'(T100_MAX) || !bus.accept_en) begin
                        bus.reject <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        if (width <= CNT_W'(T10_MAX))      bus.coin <= COIN_10;
                        else if (width <= CNT_W'(T20_MAX)) bus.coin <= COIN_20;
                        else if (width <= CNT_W'(T50_MAX)) bus.coin <= COIN_50;
                        else                               bus.coin <= COIN_100;
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    bus.drop_coin <= 1'b1;
                    coin_seen     <= 1'b1;
                    to_cnt        <= '0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
`ifdef COIN_ACCEPTOR_TALLY_EN
                    bus.credit    <= credit_sum[11] ? 11'h7FF : credit_sum[10:0];
`endif
                end
                JAM: begin
                    if (!sense_lvl) begin
                        bus.jam  <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept_rise) begin
                session_open <= 1'b1;
                to_cnt       <= '0;
                coin_seen    <= 1'b0;
`ifdef COIN_ACCEPTOR_TALLY_EN
                bus.credit   <= '0;
`endif
            end
        end
    end

endmodule
